// File: rtl/esm_issue_scheduler.sv
// Slot allocator and round-robin issue scheduler for the ESM dependency core.
// Sequences a table clear sweep after reset/flush, then allocates, issues and frees slots.
module esm_issue_scheduler #(
   parameter int bs              = 16,
   parameter int Instr_word_size = 32,
   localparam int bs_bits        = $clog2(bs)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [Instr_word_size-1:0] in_instr,
   output logic                       alloc_valid,
   output logic [bs_bits-1:0]         alloc_index,
   output logic [Instr_word_size-1:0] alloc_instr,
   input  logic [bs-1:0]              ready_vec,
   output logic                       issue_valid,
   input  logic                       issue_ready,
   output logic [bs_bits-1:0]         issue_index,
   output logic [Instr_word_size-1:0] issue_instr,
   input  logic                       cmpl_valid,
   input  logic [bs_bits-1:0]         cmpl_index,
   output logic                       clr_valid,
   output logic [bs_bits-1:0]         clr_index,
   output logic [bs_bits:0]           occupancy,
   output logic                       err
);
   typedef enum logic {INIT, RUN} state_t;
   localparam logic [1:0] FREE = 2'd0, WAIT = 2'd1, PEND = 2'd2, ISSUED = 2'd3;

   state_t                      state_q, state_d;
   logic [bs_bits:0]            cnt_q, cnt_d;
   logic [bs-1:0][1:0]          slot_q, slot_d;
   logic [bs_bits-1:0]          rr_ptr_q, rr_ptr_d;
   logic                        issue_valid_q, issue_valid_d;
   logic [bs_bits-1:0]          issue_index_q, issue_index_d;
   logic [Instr_word_size-1:0]  issue_instr_q, issue_instr_d;
   logic                        clr_valid_q, clr_valid_d;
   logic [bs_bits-1:0]          clr_index_q, clr_index_d;
   logic [bs_bits:0]            occ_q, occ_d;
   logic                        err_q, err_d;

   logic [Instr_word_size-1:0]  payload_mem [bs];

   logic                        any_free, sel_found, run, alloc_fire, issue_fire;
   logic                        cmpl_hit, cmpl_ok, load_en;
   logic [bs_bits-1:0]          free_idx, sel_idx, cand_idx;

   // Lowest free slot for allocation; round-robin search from rr_ptr for issue.
   always_comb begin
      any_free  = 1'b0;
      free_idx  = '0;
      sel_found = 1'b0;
      sel_idx   = '0;
      cand_idx  = '0;
      for (int i = bs - 1; i >= 0; i--) begin
         if (slot_q[i] == FREE) begin
            any_free = 1'b1;
            free_idx = bs_bits'(i);
         end
      end
      for (int i = 0; i < bs; i++) begin
         cand_idx = rr_ptr_q + bs_bits'(i);
         if (!sel_found && slot_q[cand_idx] == WAIT && ready_vec[cand_idx]) begin
            sel_found = 1'b1;
            sel_idx   = cand_idx;
         end
      end
   end

   assign run        = (state_q == RUN);
   assign in_ready   = run & ~flush & any_free;
   assign alloc_fire = in_valid & in_ready;
   assign issue_fire = issue_valid_q & issue_ready;
   assign cmpl_hit   = run & ~flush & cmpl_valid;
   assign cmpl_ok    = cmpl_hit & (slot_q[cmpl_index] == ISSUED);
   assign load_en    = run & ~flush & (~issue_valid_q | issue_ready);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      slot_d        = slot_q;
      rr_ptr_d      = rr_ptr_q;
      issue_valid_d = issue_valid_q;
      issue_index_d = issue_index_q;
      issue_instr_d = issue_instr_q;
      clr_valid_d   = clr_valid_q;
      clr_index_d   = clr_index_q;
      err_d         = err_q;
      occ_d         = '0;
      if (flush) begin
         state_d       = INIT;
         cnt_d         = '0;
         slot_d        = '0;
         rr_ptr_d      = '0;
         issue_valid_d = 1'b0;
         issue_index_d = '0;
         issue_instr_d = '0;
         clr_valid_d   = 1'b0;
      end else if (state_q == INIT) begin
         // cnt reaching bs means the last clear is on the outputs now.
         if (cnt_q == (bs_bits + 1)'(bs)) begin
            state_d     = RUN;
            cnt_d       = '0;
            clr_valid_d = 1'b0;
         end else begin
            cnt_d       = cnt_q + 1'b1;
            clr_valid_d = 1'b1;
            clr_index_d = cnt_q[bs_bits-1:0];
         end
      end else begin
         clr_valid_d = cmpl_ok;
         if (cmpl_ok) begin
            clr_index_d        = cmpl_index;
            slot_d[cmpl_index] = FREE;
         end
         if (cmpl_hit && !cmpl_ok) err_d = 1'b1;
         if (alloc_fire) slot_d[free_idx] = WAIT;
         if (issue_fire) slot_d[issue_index_q] = ISSUED;
         if (load_en) begin
            issue_valid_d = sel_found;
            if (sel_found) begin
               issue_index_d   = sel_idx;
               issue_instr_d   = payload_mem[sel_idx];
               slot_d[sel_idx] = PEND;
               rr_ptr_d        = sel_idx + 1'b1;
            end
         end
      end
      for (int i = 0; i < bs; i++) begin
         if (slot_d[i] != FREE) occ_d = occ_d + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (alloc_fire) payload_mem[free_idx] <= in_instr;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= INIT;
         cnt_q         <= '0;
         slot_q        <= '0;
         rr_ptr_q      <= '0;
         issue_valid_q <= 1'b0;
         issue_index_q <= '0;
         issue_instr_q <= '0;
         clr_valid_q   <= 1'b0;
         clr_index_q   <= '0;
         occ_q         <= '0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         slot_q        <= slot_d;
         rr_ptr_q      <= rr_ptr_d;
         issue_valid_q <= issue_valid_d;
         issue_index_q <= issue_index_d;
         issue_instr_q <= issue_instr_d;
         clr_valid_q   <= clr_valid_d;
         clr_index_q   <= clr_index_d;
         occ_q         <= occ_d;
         err_q         <= err_d;
      end
   end

   assign alloc_valid = alloc_fire;
   assign alloc_index = free_idx;
   assign alloc_instr = in_instr;
   assign issue_valid = issue_valid_q;
   assign issue_index = issue_index_q;
   assign issue_instr = issue_instr_q;
   assign clr_valid   = clr_valid_q;
   assign clr_index   = clr_index_q;
   assign occupancy   = occ_q;
   assign err         = err_q;
endmodule
